// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-core definitions used by the fetch path.
//   fetch_state_e  : instruction fetch sequencer states
//   INST_BYTES_DEF : default instruction size in bytes
//   inst_t         : instruction word at the default size
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDrain
    } fetch_state_e;

    localparam int unsigned INST_BYTES_DEF = 4;

    typedef logic [8*INST_BYTES_DEF-1:0] inst_t;

endpackage

// File: rtl/ifetch_seq.sv
// ----------------------------------------------------------------------------
// ifetch_seq
// Instruction fetch sequencer. Owns the PC, reads one instruction a byte at a
// time over an 8-bit req/ack memory port and presents the little-endian
// instruction to the control unit through a valid/take handshake.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   pc_inhibit_i   blocks starting a new instruction fetch
//   redirect_i     load PC from redirect_pc_i, discard the in-flight fetch
//   redirect_pc_i  redirect target (low log2(INST_BYTES) bits ignored)
//   mem_req_o      byte read request, held until acked
//   mem_addr_o     byte address, stable while a request is pending
//   mem_ack_i      byte accepted, mem_data_i valid this cycle
//   mem_data_i     read byte
//   inst_valid_o   assembled instruction available
//   inst_o         instruction, little-endian
//   inst_pc_o      address of inst_o
//   inst_take_i    control unit consumes the instruction
// ----------------------------------------------------------------------------
module ifetch_seq
    import cpu_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            INST_BYTES = INST_BYTES_DEF
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      pc_inhibit_i,
    input  logic                      redirect_i,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc_i,
    output logic                      mem_req_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    input  logic                      mem_ack_i,
    input  logic [7:0]                mem_data_i,
    output logic                      inst_valid_o,
    output logic [8*INST_BYTES-1:0]   inst_o,
    output logic [ADDR_WIDTH-1:0]     inst_pc_o,
    input  logic                      inst_take_i
);

    localparam int unsigned           SUB_W      = $clog2(INST_BYTES);
    localparam int unsigned           INST_W     = 8 * INST_BYTES;
    localparam logic [SUB_W-1:0]      LAST_SUB   = SUB_W'(INST_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);

    fetch_state_e          r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_d;
    logic [SUB_W-1:0]      r_sub, w_sub_d;
    logic [ADDR_WIDTH-1:0] r_drain_addr, w_drain_addr_d;
    logic [INST_W-1:0]     r_asm, w_asm_d;
    logic [INST_W-1:0]     r_inst, w_inst_d;
    logic [ADDR_WIDTH-1:0] r_inst_pc, w_inst_pc_d;

    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic [ADDR_WIDTH-1:0] w_redir_pc;

    assign w_fetch_addr = r_pc + ADDR_WIDTH'(r_sub);
    assign w_redir_pc   = redirect_pc_i & ALIGN_MASK;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_sub        <= '0;
            r_drain_addr <= RESET_PC;
            r_asm        <= '0;
            r_inst       <= '0;
            r_inst_pc    <= RESET_PC;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_sub        <= w_sub_d;
            r_drain_addr <= w_drain_addr_d;
            r_asm        <= w_asm_d;
            r_inst       <= w_inst_d;
            r_inst_pc    <= w_inst_pc_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_sub_d        = r_sub;
        w_drain_addr_d = r_drain_addr;
        w_asm_d        = r_asm;
        w_inst_d       = r_inst;
        w_inst_pc_d    = r_inst_pc;

        unique case (r_state)
            StIdle: begin
                if (redirect_i) begin
                    w_pc_d  = w_redir_pc;
                    w_sub_d = '0;
                end else if (!pc_inhibit_i) begin
                    w_state_d = StReq;
                end
            end

            StReq: begin
                if (redirect_i) begin
                    w_pc_d  = w_redir_pc;
                    w_sub_d = '0;
                    if (mem_ack_i) begin
                        w_state_d = StIdle;
                    end else begin
                        // The pending request must still be retired at its
                        // original address, which the new PC no longer gives.
                        w_state_d      = StDrain;
                        w_drain_addr_d = w_fetch_addr;
                    end
                end else if (mem_ack_i) begin
                    w_asm_d[{r_sub, 3'b000} +: 8] = mem_data_i;
                    if (r_sub == LAST_SUB) begin
                        // inst_o only changes here so partial bytes stay hidden.
                        w_sub_d     = '0;
                        w_inst_d    = w_asm_d;
                        w_inst_pc_d = r_pc;
                        w_state_d   = StHold;
                    end else begin
                        w_sub_d = r_sub + 1'b1;
                    end
                end
            end

            StHold: begin
                if (redirect_i) begin
                    w_pc_d    = w_redir_pc;
                    w_sub_d   = '0;
                    w_state_d = StIdle;
                end else if (inst_take_i) begin
                    w_pc_d    = r_pc + PC_STEP;
                    w_state_d = pc_inhibit_i ? StIdle : StReq;
                end
            end

            StDrain: begin
                if (redirect_i) begin
                    w_pc_d  = w_redir_pc;
                    w_sub_d = '0;
                end
                if (mem_ack_i) begin
                    w_state_d = StIdle;
                end
            end

            default: w_state_d = StIdle;
        endcase
    end

    assign mem_req_o    = (r_state == StReq) || (r_state == StDrain);
    assign mem_addr_o   = (r_state == StDrain) ? r_drain_addr : w_fetch_addr;
    assign inst_valid_o = (r_state == StHold);
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;

endmodule
